// File: rtl/iq_sweep_pkg.sv
// Shared types and widths for the IQ sweep controller.
// Optional feature macro: IQ_SWEEP_AVG_EN (per-point averaging of I/Q samples).
package iq_sweep_pkg;

    // Width of the filtered demodulator I and Q samples (signed).
    localparam int IQ_W = 14;

    // Width of the NCO phase increment.
    localparam int PHASE_W = 32;

    // Sweep sequencer states.
    //   IDLE   : waiting for a start request
    //   SETTLE : NCO retuned, waiting for the demodulator filter to settle
    //   ACQ    : collecting I/Q samples for the current point
    //   EMIT   : presenting the point result until it is accepted
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACQ    = 2'd2,
        EMIT   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/iq_sweep_accum.sv
// Sign-extending accumulate/shift datapath for one I/Q channel.
// With IQ_SWEEP_AVG_EN defined, the channel sums 2^AVG_LOG2 samples in a
// (IQ_W+AVG_LOG2)-bit accumulator and produces the arithmetic-shifted mean.
// Without IQ_SWEEP_AVG_EN no accumulator exists; the first sample is captured
// unaltered and AVG_LOG2 has no effect.
module iq_sweep_accum
    import iq_sweep_pkg::*;
#(
    parameter int AVG_LOG2 = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
`ifdef IQ_SWEEP_AVG_EN
    input  logic                   clear,
    input  logic                   acc_en,
`endif
    input  logic                   load,
    input  logic signed [IQ_W-1:0] sample,
    output logic signed [IQ_W-1:0] result
);

`ifdef IQ_SWEEP_AVG_EN
    localparam int ACC_W = IQ_W + AVG_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] avg;

    // The incoming sample is folded into the sum combinationally so the
    // final sample of a point can be loaded into the result on its own cycle.
    assign sum = acc + ACC_W'(sample);
    assign avg = sum >>> AVG_LOG2;

    // Accumulate qualified samples; load the shifted mean on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= sum;
            end
            if (load) begin
                result <= avg[IQ_W-1:0];
            end
        end
    end
`else
    // Capture the first qualified sample of the point as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (load) begin
            result <= sample;
        end
    end
`endif

endmodule

// File: rtl/iq_sweep_controller.sv
// Frequency sweep sequencer for the IQ demodulator.
// Steps the NCO phase increment through numPoints values, waits for the
// filter to settle after each retune, acquires I/Q for the point and hands
// the result downstream over a valid/ready interface.
// Optional feature macro: IQ_SWEEP_AVG_EN (average 2^AVG_LOG2 samples/point).
module iq_sweep_controller
    import iq_sweep_pkg::*;
#(
    parameter int AVG_LOG2 = 4,
    parameter int CNT_W    = 16
)
(
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [PHASE_W-1:0]      phaseStart,
    input  logic [PHASE_W-1:0]      phaseStep,
    input  logic [CNT_W-1:0]        numPoints,
    input  logic [CNT_W-1:0]        settleCycles,
    output logic [PHASE_W-1:0]      phaseInc,
    input  logic signed [IQ_W-1:0]  I,
    input  logic signed [IQ_W-1:0]  Q,
    input  logic                    iqValid,
    output logic signed [IQ_W-1:0]  resI,
    output logic signed [IQ_W-1:0]  resQ,
    output logic [CNT_W-1:0]        resIndex,
    output logic                    resValid,
    input  logic                    resReady,
    output logic                    busy,
    output logic                    done,
    output sweep_state_e            state_dbg
);

    // Result handshake: resValid is high exactly while the sequencer is in
    // EMIT; resI/resQ/resIndex are stable for as long as resValid is high.
    // A transfer happens on a rising CLK edge where resValid && resReady.
    // resValid never drops without a transfer, except on abort or reset.

    sweep_state_e state_q;
    sweep_state_e state_d;

    // Sweep parameters latched at start so later input changes are ignored.
    logic [PHASE_W-1:0] step_q;
    logic [CNT_W-1:0]   npts_q;
    logic [CNT_W-1:0]   settle_q;

    logic [CNT_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]   idx;

    logic done_d;
    logic acq_fire;
    logic last_fire;
    logic last_point;
    logic last_sample;

    assign last_point = (idx == npts_q - CNT_W'(1));
    assign acq_fire   = (state_q == ACQ) && iqValid && !abort;
    assign last_fire  = acq_fire && last_sample;

`ifdef IQ_SWEEP_AVG_EN
    localparam int SAMPLES = 1 << AVG_LOG2;

    logic [AVG_LOG2:0] samp_cnt;
    logic              acc_clear;

    // Accumulators and sample count restart on every entry into ACQ.
    assign acc_clear   = (state_q == SETTLE) && (state_d == ACQ);
    assign last_sample = (32'(samp_cnt) == 32'(SAMPLES - 1));

    // Count qualified samples taken for the current point.
    always_ff @(posedge CLK) begin
        if (reset) begin
            samp_cnt <= '0;
        end else if (acc_clear) begin
            samp_cnt <= '0;
        end else if (acq_fire) begin
            samp_cnt <= samp_cnt + (AVG_LOG2 + 1)'(1);
        end
    end
`else
    // Only the first qualified sample of a point is used.
    assign last_sample = 1'b1;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every other transition, including
    // a result handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (numPoints != '0) begin
                        state_d = SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (settle_cnt == '0) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (iqValid && last_sample) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (resReady) begin
                    if (last_point) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sweep datapath: parameter latch, retune, settle countdown, point index.
    always_ff @(posedge CLK) begin
        if (reset) begin
            phaseInc   <= '0;
            step_q     <= '0;
            npts_q     <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            idx        <= '0;
            resIndex   <= '0;
            done       <= 1'b0;
        end else begin
            done <= done_d;
            case (state_q)
                IDLE: begin
                    if (start && (numPoints != '0)) begin
                        phaseInc   <= phaseStart;
                        step_q     <= phaseStep;
                        npts_q     <= numPoints;
                        settle_q   <= settleCycles;
                        settle_cnt <= settleCycles;
                        idx        <= '0;
                    end
                end
                SETTLE: begin
                    if (!abort && (settle_cnt != '0)) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ACQ: begin
                    if (last_fire) begin
                        resIndex <= idx;
                    end
                end
                EMIT: begin
                    // Phase wraps modulo 2^32 by plain truncating addition.
                    if (!abort && resReady && !last_point) begin
                        idx        <= idx + CNT_W'(1);
                        phaseInc   <= phaseInc + step_q;
                        settle_cnt <= settle_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    iq_sweep_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum_i (
        .clk    (CLK),
        .reset  (reset),
`ifdef IQ_SWEEP_AVG_EN
        .clear  (acc_clear),
        .acc_en (acq_fire),
`endif
        .load   (last_fire),
        .sample (I),
        .result (resI)
    );

    iq_sweep_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum_q (
        .clk    (CLK),
        .reset  (reset),
`ifdef IQ_SWEEP_AVG_EN
        .clear  (acc_clear),
        .acc_en (acq_fire),
`endif
        .load   (last_fire),
        .sample (Q),
        .result (resQ)
    );

    assign resValid  = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Self-checking bench for iq_sweep_controller.
// Works with or without IQ_SWEEP_AVG_EN; the reference model follows the macro.
module tb_iq_sweep_controller;
    import iq_sweep_pkg::*;

    localparam int AVG_LOG2 = 2;
    localparam int CNT_W    = 16;
`ifdef IQ_SWEEP_AVG_EN
    localparam int NSAMP = 1 << AVG_LOG2;
`else
    localparam int NSAMP = 1;
`endif
    localparam int ENT_W = 2 * IQ_W + CNT_W;

    logic                   CLK = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   abort;
    logic [PHASE_W-1:0]     phaseStart;
    logic [PHASE_W-1:0]     phaseStep;
    logic [CNT_W-1:0]       numPoints;
    logic [CNT_W-1:0]       settleCycles;
    logic [PHASE_W-1:0]     phaseInc;
    logic signed [IQ_W-1:0] I;
    logic signed [IQ_W-1:0] Q;
    logic                   iqValid;
    logic signed [IQ_W-1:0] resI;
    logic signed [IQ_W-1:0] resQ;
    logic [CNT_W-1:0]       resIndex;
    logic                   resValid;
    logic                   resReady;
    logic                   busy;
    logic                   done;
    sweep_state_e           state_dbg;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected {resI, resQ, resIndex} per point.
    logic [ENT_W-1:0] exp_q[$];
    // Directed sample overrides consumed by the next acquisition.
    int force_i[$];
    int force_q[$];

    iq_sweep_controller #(
        .AVG_LOG2 (AVG_LOG2),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .phaseStart   (phaseStart),
        .phaseStep    (phaseStep),
        .numPoints    (numPoints),
        .settleCycles (settleCycles),
        .phaseInc     (phaseInc),
        .I            (I),
        .Q            (Q),
        .iqValid      (iqValid),
        .resI         (resI),
        .resQ         (resQ),
        .resIndex     (resIndex),
        .resValid     (resValid),
        .resReady     (resReady),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #40 CLK = ~CLK;

    initial begin
        #(80 * 40000);
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int rand14();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // Floor division for a positive divisor.
    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference result: mean (rounded toward -inf) of the first NSAMP samples.
    function automatic logic [IQ_W-1:0] model_res(input int s[$]);
        int sum;
        sum = 0;
        for (int n = 0; n < NSAMP; n++) sum += s[n];
        return IQ_W'(floor_div(sum, NSAMP));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_sweep(input logic [31:0] p0, input logic [31:0] st,
                               input int n, input int settle);
        phaseStart   = p0;
        phaseStep    = st;
        numPoints    = CNT_W'(n);
        settleCycles = CNT_W'(settle);
        start        = 1'b1;
        tick();
        start        = 1'b0;
        // Inputs change after the latch; the sweep must not follow them.
        phaseStart   = $urandom();
        phaseStep    = $urandom();
        numPoints    = CNT_W'($urandom_range(0, 20));
        settleCycles = CNT_W'($urandom_range(0, 20));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phaseInc"}, phaseInc, 32'd0);
        chk({tag, "_resI"}, 32'($unsigned(resI)), 32'd0);
        chk({tag, "_resQ"}, 32'($unsigned(resQ)), 32'd0);
        chk({tag, "_resIndex"}, 32'(resIndex), 32'd0);
        chk({tag, "_resValid"}, 32'(resValid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // One sweep point, entered at the negedge right after the retune edge.
    // mode 0: normal, 1: abort together with the handshake, 2: reset in ACQ.
    task automatic run_point(input int k, input logic [31:0] p0, input logic [31:0] st,
                             input int settle, input int stall, input bit last, input int mode);
        int si[$];
        int sq[$];
        int got;
        int iter;
        bit v;
        int vi;
        int vq;
        logic [31:0] exp_ph;
        logic [ENT_W-1:0] ent;
        logic [IQ_W-1:0] ei;
        logic [IQ_W-1:0] eq;
        logic [CNT_W-1:0] ex;

        exp_ph = p0 + 32'(k) * st;
        chk("retune_phaseInc", phaseInc, exp_ph);
        chk("settle_busy", 32'(busy), 32'd1);
        chk("settle_resValid", 32'(resValid), 32'd0);

        // Samples during settling are garbage and must be dropped; a stray
        // start request is thrown in as well.
        for (int c = 0; c <= settle; c++) begin
            iqValid = 1'b1;
            I = IQ_W'(rand14());
            Q = IQ_W'(rand14());
            if (c == 0) begin
                start      = 1'b1;
                phaseStart = $urandom();
                numPoints  = CNT_W'($urandom_range(0, 9));
            end
            tick();
            start = 1'b0;
        end

        if (mode == 2) begin
            reset   = 1'b1;
            iqValid = 1'b1;
            tick();
            reset   = 1'b0;
            iqValid = 1'b0;
            check_reset_outputs("reset_in_acq");
            return;
        end

        got  = 0;
        iter = 0;
        while (got < NSAMP) begin
            v = (force_i.size() > 0) || (iter > 12) || ($urandom_range(0, 2) != 0);
            if (force_i.size() > 0) begin
                vi = force_i.pop_front();
                vq = force_q.pop_front();
            end else begin
                vi = rand14();
                vq = rand14();
            end
            iqValid = v;
            I = IQ_W'(vi);
            Q = IQ_W'(vq);
            if (v) begin
                si.push_back(vi);
                sq.push_back(vq);
                got++;
            end
            iter++;
            tick();
        end
        iqValid = 1'b0;
        force_i.delete();
        force_q.delete();

        exp_q.push_back({model_res(si), model_res(sq), CNT_W'(k)});
        ent = exp_q.pop_front();
        {ei, eq, ex} = ent;

        chk("emit_resValid", 32'(resValid), 32'd1);
        chk("emit_resI", 32'($unsigned(resI)), 32'(ei));
        chk("emit_resQ", 32'($unsigned(resQ)), 32'(eq));
        chk("emit_resIndex", 32'(resIndex), 32'(ex));

        for (int s = 0; s < stall; s++) begin
            resReady = 1'b0;
            tick();
            chk("stall_resValid", 32'(resValid), 32'd1);
            chk("stall_resI", 32'($unsigned(resI)), 32'(ei));
            chk("stall_phaseInc", phaseInc, exp_ph);
        end

        resReady = 1'b1;
        if (mode == 1) abort = 1'b1;
        tick();
        resReady = 1'b0;
        abort    = 1'b0;

        if (mode == 1) begin
            chk("abort_hs_busy", 32'(busy), 32'd0);
            chk("abort_hs_resValid", 32'(resValid), 32'd0);
            chk("abort_hs_done", 32'(done), 32'd0);
            chk("abort_hs_phaseInc", phaseInc, exp_ph);
            tick();
            chk("abort_hs_done_later", 32'(done), 32'd0);
        end else if (last) begin
            chk("final_done", 32'(done), 32'd1);
            chk("final_busy", 32'(busy), 32'd0);
            chk("final_resValid", 32'(resValid), 32'd0);
            tick();
            chk("final_done_once", 32'(done), 32'd0);
        end
    endtask

    task automatic run_sweep(input logic [31:0] p0, input logic [31:0] st,
                             input int n, input int settle, input int max_stall);
        start_sweep(p0, st, n, settle);
        for (int k = 0; k < n; k++)
            run_point(k, p0, st, settle, $urandom_range(0, max_stall), k == n - 1, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] p;
        logic [31:0] s;

        reset = 1'b1; start = 1'b0; abort = 1'b0; iqValid = 1'b0; resReady = 1'b0;
        phaseStart = '0; phaseStep = '0; numPoints = '0; settleCycles = '0;
        I = '0; Q = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(state_dbg), 32'(IDLE));

        // Zero points: done only.
        numPoints = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_pts_done", 32'(done), 32'd1);
        chk("zero_pts_busy", 32'(busy), 32'd0);
        tick();
        chk("zero_pts_done_once", 32'(done), 32'd0);
        chk("zero_pts_idle", 32'(busy), 32'd0);

        // Single point, constant input, 10-cycle backpressure.
        s = $urandom();
        for (int n = 0; n < 4; n++) begin
            force_i.push_back(100);
            force_q.push_back(-100);
        end
        start_sweep(32'd343597384, s, 1, 3);
        run_point(0, 32'd343597384, s, 3, 10, 1'b1, 0);

        // Phase wrap across 2^32.
        start_sweep(32'hFFFF_FFF0, 32'h20, 2, 0);
        run_point(0, 32'hFFFF_FFF0, 32'h20, 0, 1, 1'b0, 0);
        run_point(1, 32'hFFFF_FFF0, 32'h20, 0, 0, 1'b1, 0);

        // Averaging with known sample sets.
        p = $urandom(); s = $urandom();
        start_sweep(p, s, 2, 1);
        force_i = '{4, 5, 6, -3};
        force_q = '{0, 0, 0, 0};
        run_point(0, p, s, 1, 0, 1'b0, 0);
        force_i = '{-1, -1, -1, -2};
        force_q = '{7, 7, 7, 7};
        run_point(1, p, s, 1, 2, 1'b1, 0);

        // Randomized sweeps.
        for (int r = 0; r < 4; r++)
            run_sweep($urandom(), $urandom(), $urandom_range(1, 4), $urandom_range(0, 5), 3);

        // Abort in SETTLE of point 2 of 5.
        p = $urandom(); s = $urandom();
        start_sweep(p, s, 5, 2);
        run_point(0, p, s, 2, 0, 1'b0, 0);
        run_point(1, p, s, 2, 1, 1'b0, 0);
        chk("abort_settle_phase_pre", phaseInc, p + 32'd2 * s);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_settle_busy", 32'(busy), 32'd0);
        chk("abort_settle_resValid", 32'(resValid), 32'd0);
        chk("abort_settle_done", 32'(done), 32'd0);
        chk("abort_settle_phaseInc", phaseInc, p + 32'd2 * s);
        tick();
        chk("abort_settle_done_later", 32'(done), 32'd0);

        // Abort concurrent with the final handshake.
        p = $urandom(); s = $urandom();
        start_sweep(p, s, 1, 1);
        run_point(0, p, s, 1, 2, 1'b1, 1);

        // Abort while idle is a no-op.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        chk("abort_idle_phaseInc", phaseInc, p);

        // Reset during ACQ of the second point.
        p = $urandom(); s = $urandom();
        start_sweep(p, s, 2, 2);
        run_point(0, p, s, 2, 0, 1'b0, 0);
        run_point(1, p, s, 2, 0, 1'b1, 2);

        // Recovery after reset.
        run_sweep($urandom(), $urandom(), 2, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
